// File: rtl/rom_loader_ctrl_pkg.sv
// Shared types and constants for the HPS ROM image loader.
// Index codes map download slots onto the three on-chip memory targets.
package rom_loader_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Encoding doubles as the bit position in the loaded flags
  typedef enum logic [1:0] {
    TGT_BIOS = 2'd0,
    TGT_SPR  = 2'd1,
    TGT_MUS  = 2'd2
  } target_e;

  localparam logic [7:0] IDX_BIOS0 = 8'd0;
  localparam logic [7:0] IDX_BIOS1 = 8'd1;
  localparam logic [7:0] IDX_SPR   = 8'd3;
  localparam logic [7:0] IDX_MUS   = 8'd4;

  localparam int unsigned DEF_BIOS_BYTES = 65536;
  localparam int unsigned DEF_SPR_BYTES  = 16384;
  localparam int unsigned DEF_MUS_BYTES  = 131072;

  localparam int CNT_W = 17;

  function automatic logic idx_is_bios(input logic [7:0] idx);
    return (idx == IDX_BIOS0) || (idx == IDX_BIOS1);
  endfunction

  function automatic logic idx_valid(input logic [7:0] idx);
    return idx_is_bios(idx) || (idx == IDX_SPR) || (idx == IDX_MUS);
  endfunction

  function automatic target_e idx_target(input logic [7:0] idx);
    target_e t;
    case (idx)
      IDX_SPR: t = TGT_SPR;
      IDX_MUS: t = TGT_MUS;
      default: t = TGT_BIOS;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rom_loader_ctrl.sv
// Steers the HPS ioctl byte stream into BIOS / sprite / music memories via a one-entry holding register.
// mem_we follows a captured byte by one cycle; ioctl_wait stalls the HPS while the register is full.
module rom_loader_ctrl
  import rom_loader_ctrl_pkg::*;
#(
  parameter int unsigned BIOS_BYTES = DEF_BIOS_BYTES,
  parameter int unsigned SPR_BYTES  = DEF_SPR_BYTES,
  parameter int unsigned MUS_BYTES  = DEF_MUS_BYTES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [1:0]  mem_sel,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        load_done,
  output logic [2:0]  loaded,
  output logic        err_range,
  output logic        err_ovf
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_dl_q;
  logic               r_pend;
  logic [7:0]         r_idx;
  target_e            r_tgt;
  logic               r_full;
  logic [16:0]        r_addr;
  logic [7:0]         r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_loaded;
  logic               r_err_range;
  logic               r_err_ovf;

  logic               w_dl_rise;
  logic               w_start;
  logic               w_load_done;
  logic               w_cpu_hold;
  logic [31:0]        w_size;
  logic               w_in_range;
  logic               w_wr_live;
  logic               w_accept;
  logic               w_ack;
  logic               w_range_err;
  logic               w_ovf_err;

  assign w_dl_rise = ioctl_download & ~r_dl_q;
  // A rise seen during DRAIN/DONE is remembered so IDLE can still take it
  assign w_start   = (r_state == ST_IDLE) && ioctl_download && (w_dl_rise || r_pend);

  always_comb begin
    w_state_nxt = r_state;
    w_load_done = 1'b0;
    w_cpu_hold  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_full) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_load_done = 1'b1;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE) w_cpu_hold = idx_is_bios(r_idx);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_size = BIOS_BYTES;
    case (r_tgt)
      TGT_SPR: w_size = SPR_BYTES;
      TGT_MUS: w_size = MUS_BYTES;
      default: w_size = BIOS_BYTES;
    endcase
  end

  assign w_in_range = ({7'd0, ioctl_addr} < w_size);
  // Bytes for an unrecognised index are swallowed silently
  assign w_wr_live   = (r_state == ST_LOAD) && ioctl_wr && idx_valid(r_idx);
  assign w_ack       = r_full && mem_ack;
  assign w_range_err = w_wr_live && !w_in_range;
  assign w_accept    = w_wr_live && w_in_range && (!r_full || mem_ack);
  assign w_ovf_err   = w_wr_live && w_in_range && r_full && !mem_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_q      <= 1'b0;
      r_pend      <= 1'b0;
      r_idx       <= 8'd0;
      r_tgt       <= TGT_BIOS;
      r_full      <= 1'b0;
      r_addr      <= 17'd0;
      r_data      <= 8'd0;
      r_cnt       <= '0;
      r_loaded    <= 3'b000;
      r_err_range <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;

      if (w_start || !ioctl_download)
        r_pend <= 1'b0;
      else if (w_dl_rise && ((r_state == ST_DRAIN) || (r_state == ST_DONE)))
        r_pend <= 1'b1;

      if (w_start) begin
        r_idx       <= ioctl_index;
        r_tgt       <= idx_target(ioctl_index);
        r_cnt       <= '0;
        r_err_range <= 1'b0;
        r_err_ovf   <= 1'b0;
      end else begin
        if (w_range_err) r_err_range <= 1'b1;
        if (w_ovf_err)   r_err_ovf   <= 1'b1;
        if (w_accept && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end

      // Accept wins over ack so a same-cycle refill keeps the register full
      if (w_accept) begin
        r_full <= 1'b1;
        r_addr <= ioctl_addr[16:0];
        r_data <= ioctl_dout;
      end else if (w_ack) begin
        r_full <= 1'b0;
      end

      if ((r_state == ST_DONE) && (r_cnt != '0)) r_loaded[r_tgt] <= 1'b1;
    end
  end

  assign ioctl_wait = r_full;
  assign mem_we     = r_full;
  assign mem_sel    = r_tgt;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign cpu_hold   = w_cpu_hold;
  assign load_done  = w_load_done;
  assign loaded     = r_loaded;
  assign err_range  = r_err_range;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_rom_loader_ctrl.sv
// Directed bench for rom_loader_ctrl: stimulus pushes expected memory writes, a negedge monitor pops and compares them.
module tb_rom_loader_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic [1:0]  mem_sel;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic        cpu_hold;
  logic        load_done;
  logic [2:0]  loaded;
  logic        err_range;
  logic        err_ovf;

  typedef struct packed {
    logic [1:0]  sel;
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   we_cycles = 0;
  int   ack_mode = 0;  // 0: ack tied high, 1: ack after 3 cycles of mem_we, 2: ack low
  int   wcnt = 0;
  logic ack_seen = 1'b0;

  rom_loader_ctrl dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_ack        (mem_ack),
    .cpu_hold       (cpu_hold),
    .load_done      (load_done),
    .loaded         (loaded),
    .err_range      (err_range),
    .err_ovf        (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a write completes on the edge following a negedge where mem_we and mem_ack are both high
  always @(negedge clk_sys) begin
    wr_t e;
    ack_seen = mem_we && mem_ack;
    if (mem_we) we_cycles++;
    if (mem_we && mem_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got sel=%0d addr=%0h data=%0h expected no write", mem_sel, mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("mem_write", 32'({mem_sel, mem_addr, mem_data}), 32'(e));
      end
    end
  end

  always @(posedge clk_sys) begin
    #1;
    if (ack_seen) wcnt = 0;
    if (mem_we) wcnt++;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (wcnt >= 3);
      default: mem_ack = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honour_wait);
    int n;
    n = 0;
    if (honour_wait) begin
      while (ioctl_wait && n < 50) begin
        n++;
        tick();
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL wait_timeout: got ioctl_wait=1 after 50 cycles expected 0");
      end
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic push(input logic [1:0] s, input logic [16:0] a, input logic [7:0] d);
    wr_t e;
    e.sel  = s;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wait_done(input logic exp_hold);
    int pulses;
    pulses = 0;
    ioctl_download = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_done) begin
        pulses++;
        check("cpu_hold_in_done", 32'(cpu_hold), 32'(exp_hold));
      end
    end
    check("load_done_pulses", pulses, 1);
    check("cpu_hold_after_done", 32'(cpu_hold), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_ioctl_wait", 32'(ioctl_wait), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_loaded", 32'(loaded), 0);
    check("rst_err_range", 32'(err_range), 0);
    check("rst_err_ovf", 32'(err_ovf), 0);
    check("rst_mem_sel", 32'(mem_sel), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    int n;
    int we0;
    logic [7:0] d;

    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // BIOS, ack tied high, back-to-back bytes exercise refill-on-ack
    ack_mode = 0;
    start_dl(8'd0);
    check("bios_cpu_hold_load", 32'(cpu_hold), 1);
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      push(2'd0, 17'(i), d);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      send_byte(25'(i), d, 1'b0);
    end
    check("bios_err_ovf", 32'(err_ovf), 0);
    wait_done(1'b1);
    check("bios_loaded", 32'(loaded), 32'b001);
    check("bios_queue_empty", exp_q.size(), 0);

    // Sprite, ack 3 cycles after mem_we
    ack_mode = 1;
    start_dl(8'd3);
    check("spr_cpu_hold", 32'(cpu_hold), 0);
    for (int i = 0; i < 3; i++) begin
      d = 8'h55 + 8'(8'h11 * i);
      push(2'd1, 17'h10 + 17'(i), d);
      send_byte(25'h10 + 25'(i), d, 1'b1);
      n = 0;
      while (ioctl_wait && n < 20) begin
        n++;
        tick();
      end
      check("spr_wait_cycles", n, 3);
    end
    check("spr_err_ovf", 32'(err_ovf), 0);
    wait_done(1'b0);
    check("spr_loaded", 32'(loaded), 32'b011);
    check("spr_queue_empty", exp_q.size(), 0);

    // Unrecognised index 7: nothing reaches memory
    ack_mode = 0;
    we0 = we_cycles;
    start_dl(8'd7);
    check("idx7_cpu_hold", 32'(cpu_hold), 0);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i), 1'b0);
    check("idx7_cpu_hold_end", 32'(cpu_hold), 0);
    wait_done(1'b0);
    check("idx7_loaded", 32'(loaded), 32'b011);
    check("idx7_no_mem_we", we_cycles - we0, 0);

    // Music: out-of-range byte dropped, in-range byte written
    start_dl(8'd4);
    send_byte(25'd131072, 8'h99, 1'b0);
    check("mus_err_range", 32'(err_range), 1);
    check("mus_no_capture", 32'(mem_we), 0);
    push(2'd2, 17'd5, 8'h3C);
    send_byte(25'd5, 8'h3C, 1'b1);
    wait_done(1'b0);
    check("mus_loaded", 32'(loaded), 32'b111);
    check("mus_err_range_sticky", 32'(err_range), 1);
    check("mus_queue_empty", exp_q.size(), 0);

    // Overflow: second byte while full and ack low is dropped
    ack_mode = 2;
    start_dl(8'd1);
    check("ovf_err_range_cleared", 32'(err_range), 0);
    push(2'd0, 17'h20, 8'h11);
    send_byte(25'h20, 8'h11, 1'b0);
    send_byte(25'h21, 8'h22, 1'b0);
    check("ovf_err_ovf", 32'(err_ovf), 1);
    check("ovf_hold_data", 32'(mem_data), 32'h11);
    ack_mode = 0;
    wait_done(1'b1);
    check("ovf_err_ovf_sticky", 32'(err_ovf), 1);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Reset mid-load with a pending write
    ack_mode = 2;
    start_dl(8'd0);
    check("ovf_cleared_on_start", 32'(err_ovf), 0);
    send_byte(25'h40, 8'hAB, 1'b0);
    check("rstload_mem_we", 32'(mem_we), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    ioctl_download = 1'b0;
    we0 = we_cycles;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rstload_no_mem_we", we_cycles - we0, 0);
    ack_mode = 0;
    start_dl(8'd0);
    check("rstload_cpu_hold", 32'(cpu_hold), 1);
    push(2'd0, 17'd0, 8'h5A);
    push(2'd0, 17'd1, 8'hC3);
    send_byte(25'd0, 8'h5A, 1'b0);
    send_byte(25'd1, 8'hC3, 1'b0);
    wait_done(1'b1);
    check("rstload_loaded", 32'(loaded), 32'b001);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
